// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the N-master AXI-Lite arbiter.
// State encodings for both channel FSMs, AXI response codes and an index-width helper.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Master-index width; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axi_lite_arbiter_nm_rr_arbiter.sv
// Combinational rotate-priority arbiter: the search starts just after ptr, so the
// previous winner has the lowest priority. Produces a one-hot grant and a valid flag.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             valid
);

    int idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_lite_arbiter_nm.sv
// N-master to 1-slave AXI-Lite arbiter with independent read and write channels,
// round-robin fairness per channel and a write-capability mask for read-only masters.
module axi_lite_arbiter_nm
    import axi_arb_pkg::*;
#(
    parameter int                NUM_M   = 3,
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 32,
    parameter int                STRB_W  = DATA_W / 8,
    parameter logic [NUM_M-1:0]  WR_MASK = 3'b110
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_M*ADDR_W-1:0]   m_awaddr,
    input  logic [NUM_M-1:0]          m_awvalid,
    output logic [NUM_M-1:0]          m_awready,
    input  logic [NUM_M*DATA_W-1:0]   m_wdata,
    input  logic [NUM_M*STRB_W-1:0]   m_wstrb,
    input  logic [NUM_M-1:0]          m_wvalid,
    output logic [NUM_M-1:0]          m_wready,
    output logic [1:0]                m_bresp,
    output logic [NUM_M-1:0]          m_bvalid,
    input  logic [NUM_M-1:0]          m_bready,
    input  logic [NUM_M*ADDR_W-1:0]   m_araddr,
    input  logic [NUM_M-1:0]          m_arvalid,
    output logic [NUM_M-1:0]          m_arready,
    output logic [DATA_W-1:0]         m_rdata,
    output logic [1:0]                m_rresp,
    output logic [NUM_M-1:0]          m_rvalid,
    input  logic [NUM_M-1:0]          m_rready,
    output logic [ADDR_W-1:0]         s_awaddr,
    output logic                      s_awvalid,
    input  logic                      s_awready,
    output logic [DATA_W-1:0]         s_wdata,
    output logic [STRB_W-1:0]         s_wstrb,
    output logic                      s_wvalid,
    input  logic                      s_wready,
    input  logic [1:0]                s_bresp,
    input  logic                      s_bvalid,
    output logic                      s_bready,
    output logic [ADDR_W-1:0]         s_araddr,
    output logic                      s_arvalid,
    input  logic                      s_arready,
    input  logic [DATA_W-1:0]         s_rdata,
    input  logic [1:0]                s_rresp,
    input  logic                      s_rvalid,
    output logic                      s_rready
);

    localparam int IDX_W = idx_w(NUM_M);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_M - 1);

    rd_state_t        rd_state;
    wr_state_t        wr_state;
    logic [IDX_W-1:0] gr_r, gr_w;
    logic [IDX_W-1:0] ptr_r, ptr_w;
    logic             aw_done, w_done;

    logic [NUM_M-1:0] rd_req, wr_req;
    logic [NUM_M-1:0] rd_grant, wr_grant;
    logic             rd_vld, wr_vld;
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic             aw_hs, w_hs;

    assign rd_req = m_arvalid;
    assign wr_req = (m_awvalid | m_wvalid) & WR_MASK;

    rr_arbiter #(.N(NUM_M), .IDX_W(IDX_W)) u_rd_arb (
        .req   (rd_req),
        .ptr   (ptr_r),
        .grant (rd_grant),
        .valid (rd_vld)
    );

    rr_arbiter #(.N(NUM_M), .IDX_W(IDX_W)) u_wr_arb (
        .req   (wr_req),
        .ptr   (ptr_w),
        .grant (wr_grant),
        .valid (wr_vld)
    );

    always_comb begin
        rd_idx = '0;
        wr_idx = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (rd_grant[i]) rd_idx = IDX_W'(i);
            if (wr_grant[i]) wr_idx = IDX_W'(i);
        end
    end

    // Read channel: grant is held from arbitration until the R handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= R_IDLE;
            gr_r     <= '0;
            ptr_r    <= PTR_RST;
        end else begin
            unique case (rd_state)
                R_IDLE: begin
                    if (rd_vld) begin
                        gr_r     <= rd_idx;
                        rd_state <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (s_arvalid && s_arready) rd_state <= R_DATA;
                end
                R_DATA: begin
                    if (s_rvalid && s_rready) begin
                        ptr_r    <= gr_r;
                        rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (gr_r == IDX_W'(i)) begin
                if (rd_state == R_ADDR) begin
                    s_araddr     = m_araddr[i*ADDR_W +: ADDR_W];
                    s_arvalid    = m_arvalid[i];
                    m_arready[i] = s_arready;
                end
                if (rd_state == R_DATA) begin
                    m_rvalid[i] = s_rvalid;
                    s_rready    = m_rready[i];
                end
            end
        end
        if (rd_state == R_DATA) begin
            m_rdata = s_rdata;
            m_rresp = s_rresp;
        end
    end

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;

    // Write channel: AW and W may complete in either order; sticky flags stop re-issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= W_IDLE;
            gr_w     <= '0;
            ptr_w    <= PTR_RST;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            unique case (wr_state)
                W_IDLE: begin
                    if (wr_vld) begin
                        gr_w     <= wr_idx;
                        wr_state <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done || aw_hs) && (w_done || w_hs)) wr_state <= W_RESP;
                end
                W_RESP: begin
                    if (s_bvalid && s_bready) begin
                        ptr_w    <= gr_w;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_bresp   = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (gr_w == IDX_W'(i)) begin
                if (wr_state == W_ADDR) begin
                    s_awaddr = m_awaddr[i*ADDR_W +: ADDR_W];
                    s_wdata  = m_wdata[i*DATA_W +: DATA_W];
                    s_wstrb  = m_wstrb[i*STRB_W +: STRB_W];
                    if (!aw_done) begin
                        s_awvalid    = m_awvalid[i];
                        m_awready[i] = s_awready;
                    end
                    if (!w_done) begin
                        s_wvalid    = m_wvalid[i];
                        m_wready[i] = s_wready;
                    end
                end
                if (wr_state == W_RESP) begin
                    m_bvalid[i] = s_bvalid;
                    s_bready    = m_bready[i];
                end
            end
        end
        if (wr_state == W_RESP) m_bresp = s_bresp;
    end

endmodule

// File: tb/tb_axi_lite_arbiter_nm.sv
// Directed bench for axi_lite_arbiter_nm with default parameters (3 masters, 32-bit).
// The slave side is driven step by step from the same sequence as the masters.
module tb_axi_lite_arbiter_nm;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              clk;
    logic              rst_n;
    logic [NM*AW-1:0]  m_awaddr;
    logic [NM-1:0]     m_awvalid;
    logic [NM-1:0]     m_awready;
    logic [NM*DW-1:0]  m_wdata;
    logic [NM*SW-1:0]  m_wstrb;
    logic [NM-1:0]     m_wvalid;
    logic [NM-1:0]     m_wready;
    logic [1:0]        m_bresp;
    logic [NM-1:0]     m_bvalid;
    logic [NM-1:0]     m_bready;
    logic [NM*AW-1:0]  m_araddr;
    logic [NM-1:0]     m_arvalid;
    logic [NM-1:0]     m_arready;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp;
    logic [NM-1:0]     m_rvalid;
    logic [NM-1:0]     m_rready;
    logic [AW-1:0]     s_awaddr;
    logic              s_awvalid;
    logic              s_awready;
    logic [DW-1:0]     s_wdata;
    logic [SW-1:0]     s_wstrb;
    logic              s_wvalid;
    logic              s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;
    logic [AW-1:0]     s_araddr;
    logic              s_arvalid;
    logic              s_arready;
    logic [DW-1:0]     s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid;
    logic              s_rready;

    int n_asserts = 0;
    int n_fail    = 0;

    axi_lite_arbiter_nm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_awaddr  (m_awaddr),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_awaddr  = '0; m_awvalid = '0; m_wdata = '0; m_wstrb = '0; m_wvalid = '0;
        m_bready  = '0; m_araddr  = '0; m_arvalid = '0; m_rready = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bresp = 2'b00; s_bvalid = 1'b0;
        s_arready = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    logic [1:0] rr_order [9] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [2:0] oh;

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        // Outputs while held in reset, even with master requests present.
        m_arvalid = 3'b111;
        m_awvalid = 3'b111;
        s_rvalid  = 1'b1;
        s_bvalid  = 1'b1;
        #1;
        chk("rst_s_arvalid", s_arvalid, 1'b0);
        chk("rst_s_awvalid", s_awvalid, 1'b0);
        chk("rst_m_rvalid", m_rvalid, 3'b000);
        chk("rst_m_bvalid", m_bvalid, 3'b000);
        chk("rst_m_arready", m_arready, 3'b000);
        chk("rst_m_rdata", m_rdata, 32'h0);
        clear_inputs();
        tick();
        rst_n = 1'b1;
        #1;

        // Single read from m1 with two slave wait states.
        m_rready = 3'b111;
        m_araddr[1*AW +: AW] = 32'h1000_0004;
        m_arvalid = 3'b010;
        #1;
        chk("rd1_idle_s_arvalid", s_arvalid, 1'b0);
        tick();
        chk("rd1_s_arvalid", s_arvalid, 1'b1);
        chk("rd1_s_araddr", s_araddr, 32'h1000_0004);
        s_arready = 1'b1;
        #1;
        chk("rd1_m_arready", m_arready, 3'b010);
        tick();
        m_arvalid = '0;
        s_arready = 1'b0;
        #1;
        chk("rd1_wait0_m_rvalid", m_rvalid, 3'b000);
        tick();
        chk("rd1_wait1_m_rvalid", m_rvalid, 3'b000);
        tick();
        s_rvalid = 1'b1;
        s_rdata  = 32'hDEAD_BEEF;
        s_rresp  = 2'b00;
        #1;
        chk("rd1_m_rvalid", m_rvalid, 3'b010);
        chk("rd1_m_rdata", m_rdata, 32'hDEAD_BEEF);
        chk("rd1_m_rresp", m_rresp, 2'b00);
        chk("rd1_s_rready", s_rready, 1'b1);
        tick();
        s_rvalid = 1'b0;
        #1;
        chk("rd1_done_m_rvalid", m_rvalid, 3'b000);
        chk("rd1_done_s_arvalid", s_arvalid, 1'b0);

        // Fairness from a fresh reset: all three masters request continuously.
        do_reset();
        m_araddr[0*AW +: AW] = 32'hA000_0000;
        m_araddr[1*AW +: AW] = 32'hA000_0100;
        m_araddr[2*AW +: AW] = 32'hA000_0200;
        m_arvalid = 3'b111;
        m_rready  = 3'b111;
        s_arready = 1'b1;
        s_rvalid  = 1'b1;
        s_rdata   = 32'h5555_AAAA;
        for (int k = 0; k < 9; k++) begin
            oh = 3'b001 << rr_order[k];
            tick();
            chk($sformatf("rr%0d_s_araddr", k), s_araddr, 32'hA000_0000 + 32'(rr_order[k]) * 32'h100);
            chk($sformatf("rr%0d_m_arready", k), m_arready, oh);
            tick();
            chk($sformatf("rr%0d_m_rvalid", k), m_rvalid, oh);
            tick();
        end
        clear_inputs();
        #1;

        // Concurrent m0 read and m2 write issued in the same cycle.
        m_araddr[0*AW +: AW] = 32'h0000_0040;
        m_arvalid = 3'b001;
        m_awaddr[2*AW +: AW] = 32'h2000_0000;
        m_wdata[2*DW +: DW]  = 32'h1234_5678;
        m_wstrb[2*SW +: SW]  = 4'hF;
        m_awvalid = 3'b100;
        m_wvalid  = 3'b100;
        m_rready  = 3'b111;
        m_bready  = 3'b111;
        #1;
        chk("cc_idle_s_arvalid", s_arvalid, 1'b0);
        chk("cc_idle_s_awvalid", s_awvalid, 1'b0);
        tick();
        chk("cc_s_arvalid", s_arvalid, 1'b1);
        chk("cc_s_awvalid", s_awvalid, 1'b1);
        chk("cc_s_wvalid", s_wvalid, 1'b1);
        chk("cc_s_araddr", s_araddr, 32'h0000_0040);
        chk("cc_s_awaddr", s_awaddr, 32'h2000_0000);
        chk("cc_s_wdata", s_wdata, 32'h1234_5678);
        chk("cc_s_wstrb", s_wstrb, 4'hF);
        s_arready = 1'b1;
        s_awready = 1'b1;
        s_wready  = 1'b1;
        #1;
        chk("cc_m_arready", m_arready, 3'b001);
        chk("cc_m_awready", m_awready, 3'b100);
        chk("cc_m_wready", m_wready, 3'b100);
        tick();
        m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
        s_arready = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
        s_bvalid  = 1'b1;
        s_bresp   = 2'b00;
        #1;
        chk("cc_m_bvalid", m_bvalid, 3'b100);
        chk("cc_m_rvalid_held", m_rvalid, 3'b000);
        tick();
        s_bvalid = 1'b0;
        s_rvalid = 1'b1;
        s_rdata  = 32'hCAFE_0001;
        #1;
        chk("cc_m_rvalid", m_rvalid, 3'b001);
        chk("cc_m_rdata", m_rdata, 32'hCAFE_0001);
        chk("cc_m_bvalid_done", m_bvalid, 3'b000);
        tick();
        clear_inputs();
        #1;

        // m1 presents W three cycles before AW; response is SLVERR.
        m_wdata[1*DW +: DW] = 32'h0BAD_F00D;
        m_wstrb[1*SW +: SW] = 4'h3;
        m_wvalid  = 3'b010;
        m_bready  = 3'b111;
        s_wready  = 1'b1;
        s_awready = 1'b1;
        tick();
        chk("wa_s_wvalid", s_wvalid, 1'b1);
        chk("wa_s_awvalid", s_awvalid, 1'b0);
        chk("wa_m_wready", m_wready, 3'b010);
        chk("wa_s_wdata", s_wdata, 32'h0BAD_F00D);
        tick();
        m_wvalid = '0;
        #1;
        chk("wa_s_wvalid_drop", s_wvalid, 1'b0);
        chk("wa_m_wready_drop", m_wready, 3'b000);
        tick();
        chk("wa_wait_m_bvalid", m_bvalid, 3'b000);
        m_awaddr[1*AW +: AW] = 32'h3000_0008;
        m_awvalid = 3'b010;
        m_wvalid  = 3'b010;
        #1;
        chk("wa_s_awvalid", s_awvalid, 1'b1);
        chk("wa_s_awaddr", s_awaddr, 32'h3000_0008);
        chk("wa_m_awready", m_awready, 3'b010);
        chk("wa_s_wvalid_gated", s_wvalid, 1'b0);
        tick();
        m_awvalid = '0;
        m_wvalid  = '0;
        s_bvalid  = 1'b1;
        s_bresp   = 2'b10;
        #1;
        chk("wa_m_bvalid", m_bvalid, 3'b010);
        chk("wa_m_bresp", m_bresp, 2'b10);
        chk("wa_s_bready", s_bready, 1'b1);
        tick();
        s_bvalid = 1'b0;
        #1;
        chk("wa_done_m_bvalid", m_bvalid, 3'b000);
        clear_inputs();
        #1;

        // Write-masked m0 requesting alone is never granted.
        m_awaddr[0*AW +: AW] = 32'h5000_0000;
        m_awvalid = 3'b001;
        s_awready = 1'b1;
        s_wready  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("mask%0d_s_awvalid", k), s_awvalid, 1'b0);
            chk($sformatf("mask%0d_m_awready", k), m_awready, 3'b000);
        end
        clear_inputs();
        #1;

        // Reset asserted while a read from m0 is in its data phase.
        m_araddr[0*AW +: AW] = 32'h0000_0080;
        m_arvalid = 3'b001;
        m_rready  = 3'b111;
        tick();
        s_arready = 1'b1;
        tick();
        m_arvalid = '0;
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rdata   = 32'h7777_7777;
        #1;
        chk("rr_pre_m_rvalid", m_rvalid, 3'b001);
        rst_n = 1'b0;
        #1;
        chk("rr_rst_m_rvalid", m_rvalid, 3'b000);
        chk("rr_rst_s_rready", s_rready, 1'b0);
        chk("rr_rst_m_rdata", m_rdata, 32'h0);
        tick();
        s_rvalid = 1'b0;
        rst_n    = 1'b1;
        #1;
        m_araddr[2*AW +: AW] = 32'h4000_0000;
        m_arvalid = 3'b100;
        tick();
        chk("rr_post_s_arvalid", s_arvalid, 1'b1);
        chk("rr_post_s_araddr", s_araddr, 32'h4000_0000);
        s_arready = 1'b1;
        #1;
        chk("rr_post_m_arready", m_arready, 3'b100);
        tick();
        clear_inputs();
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter_nm.md
Name: axi_lite_arbiter_nm

Overview:
- Parametrised N-master to 1-slave AXI-Lite arbiter; next generation of the 3-master shared-bus interconnect in the SoC.
- Read and write channels are arbitrated independently, so one master's read and another master's write can be in flight at the same time.
- Uses true round-robin fairness, carries BRESP/RRESP, and supports read-only masters through a write-capability mask.
- Sits between the core instruction/data ports, the DMA and the peripheral/memory fabric.

Parameters:
- NUM_M, 3, number of masters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (32 or 64).
- STRB_W, DATA_W/8, write-strobe width (derived).
- WR_MASK, 3'b110, bit i = 1 means master i has write channels; masked masters never win write arbitration.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  active-low reset.
- m_awaddr  in  NUM_M*ADDR_W  per-master write address, master i in slice i.
- m_awvalid / m_awready  in / out  NUM_M  per-master AW handshake.
- m_wdata  in  NUM_M*DATA_W  per-master write data.
- m_wstrb  in  NUM_M*STRB_W  per-master write strobes.
- m_wvalid / m_wready  in / out  NUM_M  per-master W handshake.
- m_bresp  out  2  write response, broadcast to all masters.
- m_bvalid / m_bready  out / in  NUM_M  per-master B handshake.
- m_araddr  in  NUM_M*ADDR_W  per-master read address.
- m_arvalid / m_arready  in / out  NUM_M  per-master AR handshake.
- m_rdata  out  DATA_W  read data, broadcast to all masters.
- m_rresp  out  2  read response, broadcast to all masters.
- m_rvalid / m_rready  out / in  NUM_M  per-master R handshake.
- s_awaddr, s_awvalid, s_awready, s_wdata, s_wstrb, s_wvalid, s_wready, s_bresp, s_bvalid, s_bready, s_araddr, s_arvalid, s_arready, s_rdata, s_rresp, s_rvalid, s_rready  slave-side AXI-Lite, same widths as above, single outstanding transaction per channel.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: both FSMs IDLE, both RR pointers = NUM_M-1 (master 0 has top priority first), all grants cleared.
- Outputs in reset: every valid/ready output 0; data/addr/resp outputs 0.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: request vector = m_arvalid. If any bit is set, register grant gr_r = RR winner and go to R_ADDR. One cycle arbitration latency.
  - R_ADDR: s_araddr/s_arvalid are muxed from gr_r; m_arready[gr_r] = s_arready. On the AR handshake go to R_DATA.
  - R_DATA: m_rvalid[gr_r] = s_rvalid; s_rready = m_rready[gr_r]. On the R handshake go to R_IDLE and set ptr_r = gr_r.
- Write FSM states: W_IDLE, W_ADDR, W_RESP.
  - W_IDLE: request vector = (m_awvalid | m_wvalid) & WR_MASK. Register grant gr_w, go to W_ADDR.
  - W_ADDR: AW and W are forwarded from gr_w in either order. Sticky flags aw_done/w_done record each handshake.
  - W_ADDR gating: s_awvalid is gated low once aw_done; s_wvalid is gated low once w_done.
  - W_ADDR exit: go to W_RESP when both handshakes have completed (same cycle or different cycles).
  - W_RESP: forward B to gr_w. On the B handshake go to W_IDLE, set ptr_w = gr_w, clear both flags.
- Round-robin: the winner is the first requester searching ptr+1, ptr+2, ... modulo NUM_M (wrap-around). The last winner has the lowest priority next round.
- Grant lock: a grant never changes between arbitration and the response handshake, even if the granted master drops valid (protocol violation, tolerated).
- Idle gating:
  - Ungranted masters see ready = 0 and bvalid/rvalid = 0.
  - Slave-side valids are 0 in IDLE states.
  - Broadcast rdata/rresp/bresp are only meaningful under the owner's valid.
- Simultaneous events: a read and a write may be granted in the same cycle to the same or different masters; the channels are fully independent.
- A response handshake and a new request in the same cycle: the FSM returns to IDLE first; the new grant is made the next cycle. There is no back-to-back bypass.
- Throughput: at most one transaction per 3 cycles per channel when the slave responds with zero wait states.
- Reset mid-operation: FSMs abort to IDLE and outputs go to 0 immediately (asynchronous). An in-flight slave response is dropped; the slave is reset by the same rst_n.
- Write-masked master asserting awvalid: it is never granted and its awready stays 0.

Decomposition:
- Package axi_arb_pkg holds:
  - rd_state_t and wr_state_t enums;
  - AXI_RESP_OKAY = 2'b00, AXI_RESP_SLVERR = 2'b10;
  - idx width localparam computed as $clog2(NUM_M).
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr; output a one-hot grant plus a valid flag; purely combinational rotate-priority.
  - Instantiated twice, once for read and once for write.
  - Pointer registers live in the parent.

Test Plan:
- Single read: m1 araddr=0x1000_0004, slave returns rdata=0xDEADBEEF, rresp=OKAY after 2 wait states -> m_rvalid[1] pulses once with 0xDEADBEEF; m_rvalid[0]=m_rvalid[2]=0 throughout; arvalid-to-s_arvalid latency is 1 cycle.
- Fairness: m0, m1, m2 hold arvalid continuously for 9 transactions -> grant order 0,1,2,0,1,2,0,1,2.
- Concurrency: m0 read and m2 write (awaddr=0x2000_0000, wdata=0x12345678, wstrb=4'hF) issued the same cycle -> s_arvalid and s_awvalid both assert the next cycle; both complete independently.
- W before AW: m1 asserts wvalid 3 cycles before awvalid -> W handshake completes first; s_wvalid drops; FSM waits for AW, then W_RESP; bresp=SLVERR is forwarded to m1 only.
- Mask: m0 (WR_MASK bit0=0) asserts awvalid alone for 20 cycles -> s_awvalid stays 0 and m_awready[0] stays 0.
- Reset mid-read: rst_n asserted low while in R_DATA -> all valids drop in the same cycle; after release, the first m_arvalid[2] request is granted normally.
